// File: rtl/mxv_dot_seq_if.sv
// Handshake/data bundle between the dot-product sequencer and its upstream
// vector mux / matrix-row source. The sequencer side uses the master modport.
interface mxv_dot_seq_if #(
    parameter int DATA_W = 16,
    parameter int N      = 8,
    parameter int SEL_W  = $clog2(N),
    parameter int ACC_W  = 2*DATA_W + SEL_W
);
    logic              start;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] vec_elem;
    logic [DATA_W-1:0] mat_elem;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;

    modport master (
        input  start, vec_elem, mat_elem,
        output sel, busy, done, result
    );

    modport slave (
        output start, vec_elem, mat_elem,
        input  sel, busy, done, result
    );
endinterface

// File: rtl/mxv_dot_seq.sv
// Walks the upstream mux select through 0..N-1, multiplies each vector element by
// its matrix-row element and accumulates one exact-width unsigned dot product.
module mxv_dot_seq #(
    parameter int DATA_W = 16,
    parameter int N      = 8,
    parameter int SEL_W  = $clog2(N),
    parameter int ACC_W  = 2*DATA_W + SEL_W
) (
    input logic           clk,
    input logic           rst,
    mxv_dot_seq_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

    state_t              state, state_n;
    logic [SEL_W-1:0]    sel_q, sel_n;
    logic [ACC_W-1:0]    acc_q, acc_n;
    logic [ACC_W-1:0]    result_q, result_n;
    logic [2*DATA_W-1:0] prod_q, prod_n;
    logic                prod_v_q, prod_v_n;
    logic                done_q, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            acc_q    <= acc_n;
            result_q <= result_n;
            prod_q   <= prod_n;
            prod_v_q <= prod_v_n;
            done_q   <= done_n;
        end
    end

    // The product register lags sel by one cycle, so the final product is folded
    // into the result during DRAIN rather than into acc.
    always_comb begin
        state_n  = state;
        sel_n    = sel_q;
        acc_n    = acc_q;
        result_n = result_q;
        prod_n   = prod_q;
        prod_v_n = prod_v_q;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_n    = '0;
                    prod_v_n = 1'b0;
                    sel_n    = '0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                prod_n   = (2*DATA_W)'(bus.vec_elem) * (2*DATA_W)'(bus.mat_elem);
                prod_v_n = 1'b1;
                if (prod_v_q) begin
                    acc_n = acc_q + ACC_W'(prod_q);
                end
                if (sel_q == LAST_SEL) begin
                    state_n = DRAIN;
                end else begin
                    sel_n = sel_q + SEL_W'(1);
                end
            end
            DRAIN: begin
                result_n = acc_q + ACC_W'(prod_q);
                done_n   = 1'b1;
                prod_v_n = 1'b0;
                sel_n    = '0;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.sel    = sel_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mxv_dot_seq.sv
// Directed and randomized bench for mxv_dot_seq; the upstream mux is modelled as
// arrays indexed by sel and results come from a plain sum-of-products model.
module tb_mxv_dot_seq;

    localparam int DATA_W     = 16;
    localparam int N          = 8;
    localparam int CLK_PERIOD = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #(CLK_PERIOD/2) clk = ~clk;

    mxv_dot_seq_if #(.DATA_W(DATA_W), .N(N)) bus ();

    logic [DATA_W-1:0] vec_arr [N];
    logic [DATA_W-1:0] mat_arr [N];

    assign bus.vec_elem = vec_arr[bus.sel];
    assign bus.mat_elem = mat_arr[bus.sel];

    mxv_dot_seq #(.DATA_W(DATA_W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  checks   = 0;
    int  failures = 0;
    time last_done_t = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: the dot product straight from the element arrays.
    function automatic longint unsigned modelDot();
        longint unsigned s = 0;
        for (int k = 0; k < N; k++) begin
            s += 64'(vec_arr[k]) * 64'(mat_arr[k]);
        end
        return s;
    endfunction

    task automatic applyStimulus(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: begin vec_arr[k] = DATA_W'(k + 1); mat_arr[k] = DATA_W'(2); end
                1: begin vec_arr[k] = 16'hFFFF;       mat_arr[k] = 16'hFFFF;   end
                2: begin vec_arr[k] = '0;             mat_arr[k] = DATA_W'($urandom_range(0, 65535)); end
                3: begin vec_arr[k] = DATA_W'(k + 2); mat_arr[k] = DATA_W'(2); end
                default: begin
                    vec_arr[k] = DATA_W'($urandom_range(0, 65535));
                    mat_arr[k] = DATA_W'($urandom_range(0, 65535));
                end
            endcase
        end
    endtask

    // Called at a negedge while idle; checks every cycle of one run through done.
    task automatic runDot(input string tag, input longint unsigned exp_result,
                          input int busy_pulse_at, input bit hold_start);
        bus.start = 1'b1;
        for (int i = 0; i <= N + 1; i++) begin
            @(negedge clk);
            if (!hold_start) bus.start = (i == busy_pulse_at);
            if (i < N + 1) begin
                checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
                checkOutput({tag, "_sel"}, 64'(bus.sel), (i < N) ? 64'(i) : 64'(N - 1));
                checkOutput({tag, "_done_early"}, 64'(bus.done), 64'd0);
            end else begin
                checkOutput({tag, "_done"}, 64'(bus.done), 64'd1);
                checkOutput({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
                checkOutput({tag, "_sel_end"}, 64'(bus.sel), 64'd0);
                checkOutput({tag, "_result"}, 64'(bus.result), exp_result);
                last_done_t = $time;
            end
        end
    endtask

    task automatic holdCheck(input string tag, input int cycles,
                             input longint unsigned exp_result);
        int done_seen  = 0;
        int busy_seen  = 0;
        int sel_moved  = 0;
        int result_bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) done_seen++;
            if (bus.busy !== 1'b0) busy_seen++;
            if (bus.sel !== '0) sel_moved++;
            if (64'(bus.result) !== exp_result) result_bad++;
        end
        checkOutput({tag, "_done_count"}, 64'(done_seen), 64'd0);
        checkOutput({tag, "_busy_count"}, 64'(busy_seen), 64'd0);
        checkOutput({tag, "_sel_moves"}, 64'(sel_moved), 64'd0);
        checkOutput({tag, "_result_changes"}, 64'(result_bad), 64'd0);
    endtask

    initial begin
        time t_first;
        $display("[TB] mxv_dot_seq bench starting");
        bus.start = 1'b0;
        applyStimulus(0);

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_sel", 64'(bus.sel), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 64'(bus.busy), 64'd0);

        applyStimulus(0);
        runDot("basic", 64'd72, -1, 1'b0);

        applyStimulus(1);
        runDot("max", 64'd34358689800, -1, 1'b0);

        applyStimulus(2);
        runDot("zero", 64'd0, -1, 1'b0);
        holdCheck("hold", 20, 64'd0);

        applyStimulus(0);
        runDot("busy_start", 64'd72, 3, 1'b0);
        holdCheck("after_busy_start", 12, 64'd72);

        applyStimulus(0);
        runDot("b2b_a", 64'd72, -1, 1'b1);
        t_first = last_done_t;
        applyStimulus(3);
        runDot("b2b_b", 64'd88, -1, 1'b1);
        bus.start = 1'b0;
        checkOutput("b2b_spacing", 64'(last_done_t - t_first), 64'(10 * CLK_PERIOD));
        holdCheck("after_b2b", 5, 64'd88);

        applyStimulus(0);
        bus.start = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checkOutput("midrst_sel_before", 64'(bus.sel), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_sel", 64'(bus.sel), 64'd0);
        checkOutput("midrst_result", 64'(bus.result), 64'd0);
        checkOutput("midrst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        holdCheck("post_rst", 12, 64'd0);
        runDot("after_rst", 64'd72, -1, 1'b0);

        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        checkOutput("rst_prio_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_prio_result", 64'(bus.result), 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("rst_prio_idle", 64'(bus.busy), 64'd0);

        repeat (4) begin
            applyStimulus(4);
            runDot("rand", modelDot(), -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
